// File: rtl/seg_scan_disp.sv
// Hex display stage: captures a 32-bit result and flags by ld/ack, then scans 8 hex digits on an active-low
// multiplexed 7-segment display. Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_disp #(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic        clka,
  input  logic        rsta,
  input  logic        ld,
  input  logic [31:0] dina,
  input  logic        ofa,
  input  logic        zfa,
  output logic        ack,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic [1:0]  led
);

  localparam logic [CNT_W-1:0] PRE_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] pre;
  logic [2:0]       idx;
  logic             tick, frame;
  logic [31:0]      hold, disp;
  logic [1:0]       hflg, dflg;
  logic             pend;
  logic [3:0]       nib;
  logic             blank;
  logic [6:0]       seg_d;

  assign tick  = (pre == PRE_MAX);
  assign frame = tick && (idx == 3'd7);
  assign nib   = disp[{idx, 2'b00} +: 4];

`ifdef SEG_LZB_EN
  // Blank a digit when it and every higher nibble are zero; digit 0 always shows.
  assign blank = (idx != 3'd0) && ((disp >> {idx, 2'b00}) == 32'd0);
`else
  assign blank = 1'b0;
`endif

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign seg_d = blank ? 7'h7F : hex7(nib);

  always_ff @(posedge clka) begin
    if (!rsta) begin
      pre  <= '0;
      idx  <= '0;
      hold <= '0;
      hflg <= '0;
      pend <= 1'b0;
      disp <= '0;
      dflg <= '0;
      ack  <= 1'b0;
      an   <= 8'hFF;
      seg  <= 8'hFF;
      led  <= 2'b00;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) idx <= idx + 3'd1;
      ack <= ld;
      if (ld) begin
        hold <= dina;
        hflg <= {ofa, zfa};
      end
      // A load coinciding with the frame keeps pend set: the new word waits for the next frame.
      if (ld)         pend <= 1'b1;
      else if (frame) pend <= 1'b0;
      if (frame && pend) begin
        disp <= hold;
        dflg <= hflg;
      end
      an  <= ~(8'b1 << idx);
      seg <= {~((idx == 3'd7) && dflg[1]), seg_d};
      led <= dflg;
    end
  end

endmodule
